// File: rtl/rotate_sched_if.sv
// Request/response bundle for rotate_sched: two requester channels and one tagged result channel.
// The master side drives requests and takes responses; the slave side is the scheduler.
interface rotate_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_data;
    logic [3:0] req0_amt;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_data;
    logic [3:0] req1_amt;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_data;
    logic       resp_id;

    modport master (
        output req0_valid, req0_data, req0_amt, input req0_ready,
        output req1_valid, req1_data, req1_amt, input req1_ready,
        output resp_ready, input resp_valid, resp_data, resp_id
    );

    modport slave (
        input req0_valid, req0_data, req0_amt, output req0_ready,
        input req1_valid, req1_data, req1_amt, output req1_ready,
        input resp_ready, output resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/rotate_sched.sv
// Round-robin scheduler sharing one 4-bit right rotator between two requesters.
// Each rotate count is executed as passes of at most 3 positions, one pass per cycle.
module rotate_sched (
    input  logic            clk,
    input  logic            reset,
    rotate_sched_if.slave   bus,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] work_data;
    logic [3:0] rem;
    logic       cur_id;
    logic [3:0] resp_data_q;
    logic       resp_id_q;
    logic       last_grant;

    logic       grant;
    logic       accept;
    logic [1:0] step;
    logic [3:0] rot_out;
    logic       last_pass;

    function automatic logic [3:0] rotr(input logic [3:0] d, input logic [1:0] k);
        logic [7:0] dd;
        dd = {d, d} >> k;
        return dd[3:0];
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        else if (bus.req1_valid)
            grant = 1'b1;
    end

    // Readies are masked while reset is high even though the state is already IDLE.
    assign accept    = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
    assign step      = (rem > 4'd3) ? 2'd3 : rem[1:0];
    assign rot_out   = rotr(work_data, step);
    assign last_pass = (rem - {2'b00, step}) == 4'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROT;
            ROT:     if (last_pass) state_nxt = DONE;
            DONE:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
        bus.resp_valid = (state == DONE);
        bus.resp_data  = resp_data_q;
        bus.resp_id    = resp_id_q;
        busy           = (state != IDLE);
    end

    // NOTE: the datapath registers are reset as well, because their reset values are visible on the response port.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_data   <= 4'd0;
            rem         <= 4'd0;
            cur_id      <= 1'b0;
            resp_data_q <= 4'd0;
            resp_id_q   <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work_data <= grant ? bus.req1_data : bus.req0_data;
                        rem       <= grant ? bus.req1_amt  : bus.req0_amt;
                        cur_id    <= grant;
                    end
                end
                ROT: begin
                    work_data <= rot_out;
                    rem       <= rem - {2'b00, step};
                    if (last_pass) begin
                        resp_data_q <= rot_out;
                        resp_id_q   <= cur_id;
                    end
                end
                DONE: begin
                    if (bus.resp_ready)
                        last_grant <= cur_id;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rotate_sched.sv
// Self-checking bench for rotate_sched: directed scenarios plus a randomized run
// compared against a cycle-level reference built from rotate/latency arithmetic.
module tb_rotate_sched;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   passed = 0;

    rotate_sched_if bus();

    rotate_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rotate: right-rotate by amt positions, done with plain integer arithmetic.
    function automatic logic [3:0] rot_ref(input logic [3:0] d, input int amt);
        int v;
        int k;
        v = int'(d);
        k = amt % 4;
        return 4'(((v >> k) | (v << (4 - k))) & 15);
    endfunction

    function automatic int lat_ref(input int amt);
        return (amt == 0) ? 1 : (amt + 2) / 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 4'd0;
        bus.req1_data  = 4'd0;
        bus.req0_amt   = 4'd0;
        bus.req1_amt   = 4'd0;
        bus.resp_ready = 1'b0;
    endtask

    // One request from a single requester, waited to completion and handshaken.
    task automatic run_one(input logic id, input logic [3:0] d, input logic [3:0] amt,
                           input logic [3:0] exp_data, input string name);
        int   cycles;
        logic rdy;
        logic other;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = amt;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = amt;
        end
        #1;
        rdy   = id ? bus.req1_ready : bus.req0_ready;
        other = id ? bus.req0_ready : bus.req1_ready;
        checks++;
        if (rdy !== 1'b1 || other !== 1'b0)
            $display("FAIL %s_ready: got rdy=%b other=%b expected 1/0", name, rdy, other);
        else passed++;
        tick();
        if (id) begin
            bus.req1_valid = 1'b0; bus.req1_data = 4'($urandom); bus.req1_amt = 4'($urandom);
        end else begin
            bus.req0_valid = 1'b0; bus.req0_data = 4'($urandom); bus.req0_amt = 4'($urandom);
        end
        cycles = 0;
        while (bus.resp_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        checks++;
        if (cycles !== lat_ref(int'(amt)))
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cycles, lat_ref(int'(amt)));
        else passed++;
        checks++;
        if (bus.resp_data !== exp_data || bus.resp_id !== id)
            $display("FAIL %s_resp: got data=%b id=%b expected data=%b id=%b",
                     name, bus.resp_data, bus.resp_id, exp_data, id);
        else passed++;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_release: got resp_valid=%b busy=%b expected 0/0", name, bus.resp_valid, busy);
        else passed++;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || bus.req0_ready !== 1'b0 ||
            bus.req1_ready !== 1'b0 || bus.resp_data !== 4'd0 || bus.resp_id !== 1'b0)
            $display("FAIL reset_state: got rv=%b busy=%b r0=%b r1=%b data=%b id=%b expected all 0",
                     bus.resp_valid, busy, bus.req0_ready, bus.req1_ready, bus.resp_data, bus.resp_id);
        else passed++;
        reset = 1'b0;
        run_one(1'b0, 4'b1010, 4'd3, 4'b0101, "reset_first_tie");
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_single();
        run_one(1'b0, 4'b0011, 4'd1, 4'b1001, "single_amt1");
        run_one(1'b0, 4'b0011, 4'd0, 4'b0011, "single_amt0");
        run_one(1'b1, 4'b1100, 4'd3, 4'b1001, "single_amt3");
    endtask

    task automatic test_multipass();
        run_one(1'b1, 4'b0001, 4'd7,  4'b0010, "multi_amt7");
        run_one(1'b1, 4'b0001, 4'd15, 4'b0010, "multi_amt15");
        run_one(1'b0, 4'b0110, 4'd4,  4'b0110, "multi_amt4");
    endtask

    task automatic test_arbitration();
        int   got;
        int   cyc;
        logic both;
        logic [3:0] exp_data;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 4'b1000; bus.req0_amt = 4'd2;
        bus.req1_valid = 1'b1; bus.req1_data = 4'b0100; bus.req1_amt = 4'd2;
        bus.resp_ready = 1'b1;
        got  = 0;
        cyc  = 0;
        both = 1'b0;
        while (got < 4 && cyc < 100) begin
            if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) both = 1'b1;
            if (bus.resp_valid === 1'b1) begin
                exp_data = (got % 2 == 0) ? 4'b0010 : 4'b0001;
                checks++;
                if (bus.resp_id !== 1'(got % 2) || bus.resp_data !== exp_data)
                    $display("FAIL arb_resp%0d: got id=%b data=%b expected id=%0d data=%b",
                             got, bus.resp_id, bus.resp_data, got % 2, exp_data);
                else passed++;
                got++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (got !== 4 || both !== 1'b0)
            $display("FAIL arb_summary: got responses=%0d both_ready=%b expected 4/0", got, both);
        else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        int   cyc;
        logic bad;
        idle_inputs();
        bus.req1_valid = 1'b1; bus.req1_data = 4'b0110; bus.req1_amt = 4'd5;
        #1;
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 4'b1111; bus.req0_amt = 4'd1;
        cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 4'b0011 || bus.resp_id !== 1'b1 ||
                busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0 || cyc !== 2)
            $display("FAIL backpressure_hold: got unstable=%b wait=%0d data=%b expected 0/2/0011",
                     bad, cyc, bus.resp_data);
        else passed++;
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req0_ready !== 1'b1)
            $display("FAIL backpressure_release: got busy=%b rv=%b r0=%b expected 0/0/1",
                     busy, bus.resp_valid, bus.req0_ready);
        else passed++;
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        logic seen;
        idle_inputs();
        bus.req0_valid = 1'b1; bus.req0_data = 4'b1011; bus.req0_amt = 4'd12;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_data !== 4'd0 || bus.resp_id !== 1'b0)
            $display("FAIL midop_reset_state: got busy=%b rv=%b data=%b id=%b expected 0/0/0000/0",
                     busy, bus.resp_valid, bus.resp_data, bus.resp_id);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL midop_no_resp: got response after reset expected none");
        else passed++;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
            $display("FAIL midop_next_tie: got r0=%b r1=%b expected 1/0", bus.req0_ready, bus.req1_ready);
        else passed++;
        idle_inputs();
        tick();
    endtask

    // Randomized traffic against a reference that tracks only busy/response and a cycle countdown.
    task automatic test_random();
        logic       m_busy;
        logic       m_resp;
        logic       m_last;
        logic       m_id;
        logic [3:0] m_data;
        int         m_wait;
        logic       g;
        logic       e0;
        logic       e1;
        int         responses;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_id = 1'b0; m_data = 4'd0; m_wait = 0;
        responses = 0;
        for (int c = 0; c < 600; c++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_data  = 4'($urandom);
            bus.req1_data  = 4'($urandom);
            bus.req0_amt   = 4'($urandom);
            bus.req1_amt   = 4'($urandom);
            bus.resp_ready = 1'($urandom_range(0, 1));
            #1;
            g  = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
            e0 = !m_busy && bus.req0_valid && !g;
            e1 = !m_busy && bus.req1_valid && g;
            checks++;
            if (bus.req0_ready !== e0 || bus.req1_ready !== e1 || busy !== m_busy || bus.resp_valid !== m_resp)
                $display("FAIL rand_ctrl@%0d: got r0=%b r1=%b busy=%b rv=%b expected %b %b %b %b",
                         c, bus.req0_ready, bus.req1_ready, busy, bus.resp_valid, e0, e1, m_busy, m_resp);
            else passed++;
            if (m_resp) begin
                checks++;
                if (bus.resp_data !== m_data || bus.resp_id !== m_id)
                    $display("FAIL rand_resp@%0d: got data=%b id=%b expected data=%b id=%b",
                             c, bus.resp_data, bus.resp_id, m_data, m_id);
                else passed++;
            end
            if (e0 || e1) begin
                m_busy = 1'b1;
                m_id   = e1;
                m_data = e1 ? rot_ref(bus.req1_data, int'(bus.req1_amt)) : rot_ref(bus.req0_data, int'(bus.req0_amt));
                m_wait = e1 ? lat_ref(int'(bus.req1_amt)) : lat_ref(int'(bus.req0_amt));
            end else if (m_busy && !m_resp) begin
                m_wait--;
                if (m_wait == 0) m_resp = 1'b1;
            end else if (m_resp && bus.resp_ready) begin
                m_resp = 1'b0;
                m_busy = 1'b0;
                m_last = m_id;
                responses++;
            end
            tick();
        end
        checks++;
        if (responses < 20)
            $display("FAIL rand_progress: got %0d responses expected at least 20", responses);
        else passed++;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multipass();
        test_arbitration();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
